// File: rtl/fifo_pkg.sv
// Shared helpers for the P2 async FIFO pointer logic.
// Gray/binary conversion and synchroniser defaults.
package fifo_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int PTR_MAX_W = 32;

  // Width-agnostic: callers zero-extend to PTR_MAX_W
  // and cast the result back to their pointer width.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(
    input logic [PTR_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits convert to zero upper bits, so the
  // low slice is correct for any narrower pointer.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(
    input logic [PTR_MAX_W-1:0] g
  );
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_ptr_sync.sv
// N-stage flop chain bringing a Gray pointer into this clock domain.
// Ports: clk_i, rst_ni (async low), d_i (async pointer), q_o (last stage).
module ptr_sync
  import fifo_pkg::*;
#(
  parameter int W      = 5,
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] rq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rq_q <= '0;
    end else begin
      rq_q <= {rq_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = rq_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for the P2 async FIFO.
// Ports: clk_in, reset_n, wr_en, rd_ptr_gray in; mem_we, wr_addr,
// wr_ptr_gray, full, almost_full, wr_level, overflow out.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int AF_MARGIN   = 2,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              mem_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] AF_TH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          accept;
  logic [PW-1:0] rq_s;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] rq_full;

  ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk_i  (clk_in),
    .rst_ni (reset_n),
    .d_i    (rd_ptr_gray),
    .q_o    (rq_s)
  );

  // Write pointer value that is exactly DEPTH ahead of the read pointer.
  assign rq_full = {~rq_s[ADDR_W:ADDR_W-1], rq_s[ADDR_W-2:0]};

  always_comb begin
    accept    = wr_en & ~full_q;
    wr_bin_d  = wr_bin_q + PW'(accept);
    wr_gray_d = PW'(bin2gray(PTR_MAX_W'(wr_bin_d)));
    rd_bin_s  = PW'(gray2bin(PTR_MAX_W'(rq_s)));
    level_d   = wr_bin_d - rd_bin_s;
    full_d    = (wr_gray_d == rq_full);
    af_d      = (level_d >= AF_TH);
    ovf_d     = wr_en & full_q;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
    end
  end

  assign mem_we      = accept;
  assign wr_addr     = wr_bin_q[ADDR_W-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule
